// File: rtl/fetch_npc_pkg.sv
// Shared constants for the IF stage: next-PC mode codes and the reset PC.
package fetch_npc_pkg;

  // Next-PC modes produced by the ID decoder.
  localparam logic [2:0] NPC_PC4    = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_J      = 3'd2;
  localparam logic [2:0] NPC_JR     = 3'd3;

  // PC after reset; also the instruction-memory base address.
  localparam logic [31:0] PC_RESET_BASE = 32'h0000_3000;

  // Sign-extended branch offset in bytes (word offset shifted left by 2).
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_npc_calc.sv
// Combinational next-PC selector. The ID-stage instruction's PC is if_id_pc,
// so branch and jump targets are formed from it; sequential fetch uses pc.
module npc_calc
  import fetch_npc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] if_id_pc,
  input  logic [2:0]  npc_op,
  input  logic        cmp_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] rs_fwd,
  output logic [31:0] npc
);

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = if_id_pc + 32'd4 + branch_offset(imm16);
  assign jump_target   = {if_id_pc[31:28], index26, 2'b00};

  // Pick the redirect target; unknown modes fall back to sequential fetch.
  always_comb begin
    npc = pc_plus4;
    case (npc_op)
      NPC_PC4:    npc = pc_plus4;
      NPC_BRANCH: npc = cmp_taken ? branch_target : pc_plus4;
      NPC_J:      npc = jump_target;
      NPC_JR:     npc = rs_fwd;
      default:    npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_npc.sv
// IF stage: PC register, next-PC selection and the IF/ID pipeline register.
// Branches and jumps resolve in ID with one delay slot, so nothing is flushed;
// a stall freezes every register, and the redirect applies on the first
// non-stalled edge with whatever operands are present at that edge.
module fetch_npc
  import fetch_npc_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  npc_op,
  input  logic        cmp_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] rs_fwd,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc8
);

  logic [31:0] npc;

  npc_calc u_npc_calc (
    .pc        (pc),
    .if_id_pc  (if_id_pc),
    .npc_op    (npc_op),
    .cmp_taken (cmp_taken),
    .imm16     (imm16),
    .index26   (index26),
    .rs_fwd    (rs_fwd),
    .npc       (npc)
  );

  // PC and IF/ID update; reset dominates stall and any pending redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= PC_RESET;
      if_id_instr <= 32'd0;
      if_id_pc    <= 32'd0;
      if_id_pc8   <= 32'd0;
    end else if (!stall) begin
      pc          <= npc;
      if_id_instr <= instr_in;
      if_id_pc    <= pc;
      if_id_pc8   <= pc + 32'd8;
    end
  end

endmodule

// File: tb/tb_fetch_npc.sv
// Bench for fetch_npc: a table of per-edge stimulus with expected register
// contents, applied in order from reset, plus a random-length stall sequence.
module tb_fetch_npc;

  localparam logic [2:0] OP_PC4 = 3'd0;
  localparam logic [2:0] OP_BR  = 3'd1;
  localparam logic [2:0] OP_J   = 3'd2;
  localparam logic [2:0] OP_JR  = 3'd3;

  // clock / reset and DUT signals
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  npc_op = 3'd0;
  logic        cmp_taken = 1'b0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] index26 = 26'd0;
  logic [31:0] rs_fwd = 32'd0;
  logic [31:0] instr_in;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc8;

  always #5 clk = ~clk;

  fetch_npc dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .npc_op      (npc_op),
    .cmp_taken   (cmp_taken),
    .imm16       (imm16),
    .index26     (index26),
    .rs_fwd      (rs_fwd),
    .instr_in    (instr_in),
    .pc          (pc),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_pc8   (if_id_pc8)
  );

  // Instruction memory model: a fixed, address-dependent pattern.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  always_comb instr_in = imem(pc);

  typedef struct {
    logic        rst;
    logic        stl;
    logic [2:0]  op;
    logic        tkn;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
    logic [31:0] epc;
    logic [31:0] eifpc;
    logic [31:0] epc8;
  } vec_t;

  vec_t vecs[$];
  logic [127:0] exp_q[$];   // {pc, if_id_instr, if_id_pc, if_id_pc8}
  int compared = 0;
  int mismatched = 0;

  task automatic add(input logic rst, input logic stl, input logic [2:0] op,
                     input logic tkn, input logic [15:0] imm, input logic [25:0] idx,
                     input logic [31:0] rs, input logic [31:0] epc,
                     input logic [31:0] eifpc, input logic [31:0] epc8);
    vec_t v;
    v.rst = rst; v.stl = stl; v.op = op; v.tkn = tkn; v.imm = imm;
    v.idx = idx; v.rs = rs; v.epc = epc; v.eifpc = eifpc; v.epc8 = epc8;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // driver: apply one edge worth of stimulus, push expectation, then compare
  task automatic step(input vec_t v, input string tag);
    logic [127:0] e;
    logic [31:0]  e_instr;
    @(negedge clk);
    reset = v.rst; stall = v.stl; npc_op = v.op; cmp_taken = v.tkn;
    imm16 = v.imm; index26 = v.idx; rs_fwd = v.rs;
    e_instr = (v.epc8 == 32'd0) ? 32'd0 : imem(v.eifpc);
    exp_q.push_back({v.epc, e_instr, v.eifpc, v.epc8});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".pc"},          pc,          e[127:96]);
    check({tag, ".if_id_instr"}, if_id_instr, e[95:64]);
    check({tag, ".if_id_pc"},    if_id_pc,    e[63:32]);
    check({tag, ".if_id_pc8"},   if_id_pc8,   e[31:0]);
  endtask

  initial begin
    vec_t v;
    int n;
    logic [25:0] ridx;

    // 1: reset held two edges, then sequential fetch
    add(1, 0, OP_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h3000, 32'h0, 32'h0);
    add(1, 0, OP_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h3000, 32'h0, 32'h0);
    add(0, 0, OP_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h3004, 32'h3000, 32'h3008);
    add(0, 0, OP_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 32'h3004, 32'h300C);
    // 2: beq at 0x3008 in IF/ID, taken, imm 3 -> delay slot 0x300C latched, pc 0x3018
    add(0, 0, OP_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h300C, 32'h3008, 32'h3010);
    add(0, 0, OP_BR,  1, 16'h3, 26'h0, 32'h0, 32'h3018, 32'h300C, 32'h3014);
    // 3a: same setup, not taken -> 0x3010
    add(1, 0, OP_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h3000, 32'h0, 32'h0);
    add(0, 0, OP_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h3004, 32'h3000, 32'h3008);
    add(0, 0, OP_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 32'h3004, 32'h300C);
    add(0, 0, OP_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h300C, 32'h3008, 32'h3010);
    add(0, 0, OP_BR,  0, 16'h3, 26'h0, 32'h0, 32'h3010, 32'h300C, 32'h3014);
    // 3b: negative offset, taken: 0x3008 + 4 - 8 = 0x3004
    add(1, 0, OP_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h3000, 32'h0, 32'h0);
    add(0, 0, OP_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h3004, 32'h3000, 32'h3008);
    add(0, 0, OP_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 32'h3004, 32'h300C);
    add(0, 0, OP_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h300C, 32'h3008, 32'h3010);
    add(0, 0, OP_BR,  1, 16'hFFFE, 26'h0, 32'h0, 32'h3004, 32'h300C, 32'h3014);
    // 4a: jal at 0x3000, index 0xC10 -> 0x3040
    add(1, 0, OP_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h3000, 32'h0, 32'h0);
    add(0, 0, OP_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h3004, 32'h3000, 32'h3008);
    add(0, 0, OP_J,   0, 16'h0, 26'h0000C10, 32'h0, 32'h3040, 32'h3004, 32'h300C);
    // 4b: jr at 0x3040 stalled two edges while rs_fwd changes
    add(0, 0, OP_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h3044, 32'h3040, 32'h3048);
    add(0, 1, OP_JR,  0, 16'h0, 26'h0, 32'h1234, 32'h3044, 32'h3040, 32'h3048);
    add(0, 1, OP_JR,  0, 16'h0, 26'h0, 32'h1234, 32'h3044, 32'h3040, 32'h3048);
    add(0, 0, OP_JR,  0, 16'h0, 26'h0, 32'h3100, 32'h3100, 32'h3044, 32'h304C);
    // 5a: pc wrap via jr, then sequential; branch target wrap below zero
    add(0, 0, OP_JR,  0, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h3100, 32'h3108);
    add(0, 0, OP_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h4);
    add(0, 0, OP_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h4, 32'h0, 32'h8);
    add(0, 0, OP_BR,  1, 16'hFFFE, 26'h0, 32'h0, 32'hFFFF_FFFC, 32'h4, 32'hC);
    // 5b: reset with taken branch and stall -> reset wins
    add(1, 1, OP_BR,  1, 16'h3, 26'h0, 32'h0, 32'h3000, 32'h0, 32'h0);
    // undefined modes fall back to pc + 4
    add(0, 0, 3'd7,   1, 16'h3, 26'h3FFFFFF, 32'hDEAD_BEEC, 32'h3004, 32'h3000, 32'h3008);
    add(0, 0, 3'd4,   1, 16'h3, 26'h3FFFFFF, 32'hDEAD_BEEC, 32'h3008, 32'h3004, 32'h300C);

    foreach (vecs[i]) step(vecs[i], $sformatf("v%0d", i));

    // random-length stall with random redirect requests, then a jump
    v.rst = 1; v.stl = 0; v.op = OP_PC4; v.tkn = 0; v.imm = 0; v.idx = 0; v.rs = 0;
    v.epc = 32'h3000; v.eifpc = 32'h0; v.epc8 = 32'h0;
    step(v, "rs_reset");
    v.rst = 0; v.epc = 32'h3004; v.eifpc = 32'h3000; v.epc8 = 32'h3008;
    step(v, "rs_pc4");
    n = $urandom_range(1, 4);
    for (int k = 0; k < n; k++) begin
      v.stl = 1;
      v.op  = 3'($urandom_range(0, 3));
      v.tkn = 1'($urandom_range(0, 1));
      v.imm = 16'($urandom);
      v.idx = 26'($urandom);
      v.rs  = $urandom;
      step(v, $sformatf("rs_stall%0d", k));
    end
    ridx = 26'($urandom);
    v.stl = 0; v.op = OP_J; v.idx = ridx;
    v.epc = {4'h0, ridx, 2'b00}; v.eifpc = 32'h3004; v.epc8 = 32'h300C;
    step(v, "rs_jump");

    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
